// File: rtl/cache_line_mem_responder_if.sv
// ============================================================================
// cache_line_mem_responder_if
// Line request/response bus between a cache miss controller and memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_line_mem_responder_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [255:0] req_line;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_write;
  logic [255:0] resp_line;
  logic         busy;
`ifdef MEM_RESP_ERR_EN
  logic         resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_line, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_line, busy, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_line, resp_ready,
    output req_ready, resp_valid, resp_write, resp_line, busy, resp_err
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_line, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_line, busy
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_line, resp_ready,
    output req_ready, resp_valid, resp_write, resp_line, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/cache_line_mem_responder.sv
// ============================================================================
// cache_line_mem_responder
// Serves 8-beat line refills/writebacks from a word-wide RAM after LATENCY
// wait cycles. Optional feature macro: MEM_RESP_ERR_EN (out-of-range error).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_line_mem_responder #(
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int LATENCY        = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  cache_line_mem_responder_if.slave   bus
);

  localparam int MEM_DEPTH = 1 << MEM_WORDS_LOG2;
  localparam int LINE_W    = MEM_WORDS_LOG2 - 3;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [2:0]          beat_q, beat_d;
  logic                write_q, write_d;
  logic [LINE_W-1:0]   line_idx_q, line_idx_d;
  logic [255:0]        line_q, line_d;
  logic                err_q, err_d;

  logic [31:0]         mem [MEM_DEPTH];
  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic [7:0]          beat_bit;
  logic [31:0]         mem_rdata;
  logic [31:0]         mem_wdata;
  logic                mem_we;
  logic                req_err;

`ifdef MEM_RESP_ERR_EN
  assign req_err = |bus.req_addr[31:MEM_WORDS_LOG2+2];

  logic unused_addr;
  assign unused_addr = &{1'b0, bus.req_addr[4:0]};
`else
  // Upper address bits are dropped so accesses alias modulo the RAM size.
  assign req_err = 1'b0;

  logic unused_addr;
  assign unused_addr = &{1'b0, bus.req_addr[4:0], bus.req_addr[31:MEM_WORDS_LOG2+2]};
`endif

  assign word_idx  = {line_idx_q, beat_q};
  assign beat_bit  = {beat_q, 5'b0};
  assign mem_rdata = mem[word_idx];
  assign mem_wdata = line_q[beat_bit +: 32];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_d     = beat_q;
    write_d    = write_q;
    line_idx_d = line_idx_q;
    line_d     = line_q;
    err_d      = err_q;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          line_idx_d = bus.req_addr[MEM_WORDS_LOG2+1:5];
          // Reads start from zero so an errored refill returns an empty line.
          line_d     = bus.req_write ? bus.req_line : '0;
          err_d      = req_err;
          wait_cnt_d = '0;
          beat_d     = 3'd0;
          state_d    = (LATENCY > 0) ? ST_WAIT : ST_XFER;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = ST_XFER;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (!err_q) begin
          if (write_q) begin
            mem_we = 1'b1;
          end else begin
            line_d[beat_bit +: 32] = mem_rdata;
          end
        end
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      beat_q     <= 3'd0;
      write_q    <= 1'b0;
      line_idx_q <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_q     <= beat_d;
      write_q    <= write_d;
      line_idx_q <= line_idx_d;
      line_q     <= line_d;
      err_q      <= err_d;
    end
  end

  // Write enable comes from the async-reset state, so a reset edge never writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= mem_wdata;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_write = write_q;
  assign bus.resp_line  = line_q;
  assign bus.busy       = (state_q != ST_IDLE);
`ifdef MEM_RESP_ERR_EN
  assign bus.resp_err   = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_line_mem_responder.sv
// ============================================================================
// tb_cache_line_mem_responder
// Scoreboard bench: stimulus pushes expected responses, a monitor checks them.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_line_mem_responder;

  localparam int LAT = 4;
  localparam int AW  = 12;

  typedef struct {
    bit           w;
    logic [255:0] line;
    bit           err;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   rr_mode;
  bit   seen_rise;
  bit   expect_idle;

  exp_t        sbq[$];
  logic [31:0] mm[int];
  int          pool[8];

  cache_line_mem_responder_if bus ();

  cache_line_mem_responder #(
    .MEM_WORDS_LOG2 (AW),
    .LATENCY        (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] pat(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base | k;
    return l;
  endfunction

  // Memory seen as a map of word index -> data; a line is 8 consecutive words.
  function automatic logic [255:0] model_access(input bit w, input logic [31:0] a,
                                                input logic [255:0] l, output bit er);
    logic [255:0] r;
    int li;
    li = int'((a >> 5) % (1 << (AW - 3)));
`ifdef MEM_RESP_ERR_EN
    er = ((a >> (AW + 2)) != 0);
`else
    er = 1'b0;
`endif
    r = '0;
    if (w) begin
      r = l;
      if (!er) for (int k = 0; k < 8; k++) mm[li*8 + k] = l[k*32 +: 32];
    end else if (!er) begin
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = mm.exists(li*8 + k) ? mm[li*8 + k] : 32'hx;
    end
    return r;
  endfunction

  task automatic do_req(input bit w, input logic [31:0] a, input logic [255:0] l,
                        input bit push, output int acc);
    int   n;
    bit   er;
    exp_t e;
    n   = 0;
    acc = -1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_line  = l;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_ready expected=ready addr=%h", a);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      bus.req_valid = 1'b0;
      bus.req_write = $urandom;
      bus.req_addr  = $urandom;
      bus.req_line  = rand_line();
      if (push) begin
        e.line = model_access(w, a, l, er);
        e.w    = w;
        e.err  = er;
        e.acc  = acc;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !bus.req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0 || !bus.req_ready) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", sbq.size());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.resp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.resp_ready = 1'b0;
        default: bus.resp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: every cycle a response is shown it must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (expect_idle) begin
        chk("idle_req_ready", 256'(bus.req_ready), 256'(1));
        chk("idle_resp_valid", 256'(bus.resp_valid), 256'(0));
        expect_idle = 1'b0;
      end
      if (bus.resp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=resp_valid expected=none");
        end else begin
          if (!seen_rise) begin
            chk("latency", 256'(cyc), 256'(sbq[0].acc + LAT + 8));
            seen_rise = 1'b1;
          end
          chk("resp_line", bus.resp_line, sbq[0].line);
          chk("resp_write", 256'(bus.resp_write), 256'(sbq[0].w));
          chk("resp_req_ready", 256'(bus.req_ready), 256'(0));
          chk("resp_busy", 256'(bus.busy), 256'(1));
`ifdef MEM_RESP_ERR_EN
          chk("resp_err", 256'(bus.resp_err), 256'(sbq[0].err));
`endif
          if (bus.resp_ready) begin
            void'(sbq.pop_front());
            seen_rise   = 1'b0;
            expect_idle = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 256'(bus.req_ready), 256'(1));
    chk({tag, "_resp_valid"}, 256'(bus.resp_valid), 256'(0));
    chk({tag, "_resp_write"}, 256'(bus.resp_write), 256'(0));
    chk({tag, "_resp_line"}, bus.resp_line, 256'(0));
    chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
`ifdef MEM_RESP_ERR_EN
    chk({tag, "_resp_err"}, 256'(bus.resp_err), 256'(0));
`endif
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          n;
    logic [31:0] a;
    logic [31:0] hi;
    checks        = 0;
    errors        = 0;
    rr_mode       = 2;
    seen_rise     = 1'b0;
    expect_idle   = 1'b0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_line  = '0;
    bus.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    pool[0] = 2;
    pool[1] = 4;
    pool[2] = 8;
    for (int i = 3; i < 8; i++) pool[i] = $urandom_range(0, (1 << (AW - 3)) - 1);
    for (int i = 0; i < 8; i++) do_req(1'b1, 32'(pool[i]) << 5, rand_line(), 1'b1, acc);

    // Write then read back a line; offset bits ignored.
    do_req(1'b1, 32'h0000_0040, pat(32'hA000_0000), 1'b1, acc);
    do_req(1'b0, 32'h0000_0040, '0, 1'b1, acc);
    do_req(1'b0, 32'h0000_005C, '0, 1'b1, acc);

    // Response held off for several cycles.
    drain();
    rr_mode = 1;
    do_req(1'b0, 32'h0000_0040, '0, 1'b1, acc);
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rr_mode = 2;
    drain();

    // Reset in the middle of a writeback: beats 0..2 land, 3..7 keep old data.
    rr_mode = 0;
    do_req(1'b1, 32'h0000_0080, pat(32'hD000_0000), 1'b1, acc);
    drain();
    do_req(1'b1, 32'h0000_0080, pat(32'hB000_0000), 1'b0, acc);
    repeat (LAT + 3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    seen_rise   = 1'b0;
    expect_idle = 1'b0;
    #1;
    chk_reset_outputs("mid_xfer_reset");
    for (int k = 0; k < 3; k++) mm[4*8 + k] = 32'hB000_0000 | k;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0080, '0, 1'b1, acc);

    // Aliasing (or error) for an address beyond the RAM.
    do_req(1'b1, 32'h0000_4040, pat(32'hC000_0000), 1'b1, acc);
    do_req(1'b0, 32'h0000_0040, '0, 1'b1, acc);

    for (int i = 0; i < 40; i++) begin
      hi = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0003_FFFF) : 32'h0;
      a  = (hi << (AW + 2)) | (32'(pool[$urandom_range(0, 7)]) << 5) | ($urandom & 32'h1F);
      if ($urandom_range(0, 1) == 1) do_req(1'b1, a, rand_line(), 1'b1, acc);
      else                           do_req(1'b0, a, '0, 1'b1, acc);
    end

    drain();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
